// File: rtl/logic_op_pkg.sv
`default_nettype none
// ============================================================================
// Module : logic_op_pkg
// Brief  : Opcode enum, default widths and request record for the responder.
// Rev    : 1.0
// ============================================================================
package logic_op_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_ANDN  = 3'b101,
    OP_PASSA = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_TAG_W-1:0] tag;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/logic_op_responder_if.sv
`default_nettype none
// ============================================================================
// Module : logic_op_responder_if
// Brief  : Request and response valid/ready channels of the logic responder.
// Rev    : 1.0
// ============================================================================
interface logic_op_responder_if
  import logic_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
);
  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_zero, rsp_neg, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_zero, rsp_neg, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ============================================================================
// Module : logic_op_core
// Brief  : Combinational bitwise logic unit with zero/negative/error flags.
// Rev    : 1.0
// ============================================================================
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             err_o
);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_NOR:   result_o = ~(a_i | b_i);
      OP_NAND:  result_o = ~(a_i & b_i);
      OP_ANDN:  result_o = a_i & ~b_i;
      OP_PASSA: result_o = a_i;
      default:  err_o    = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign neg_o  = result_o[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/logic_op_responder.sv
`default_nettype none
// ============================================================================
// Module : logic_op_responder
// Brief  : Two-stage pipelined logic responder with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module logic_op_responder
  import logic_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_op_responder_if.slave   bus,
  output logic [CNT_W-1:0]      done_count_o
);

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_neg_q,   s2_neg_d;
  logic             s2_err_q,   s2_err_d;

  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic             s2_free, accept, s1_adv, consume;
  logic [WIDTH-1:0] core_result;
  logic             core_zero, core_neg, core_err;

  // Ready looks through a draining S2 so a full pipe still streams 1/cycle.
  assign s2_free = !s2_valid_q || bus.rsp_ready;
  assign accept  = bus.req_valid && bus.req_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign consume = s2_valid_q && bus.rsp_ready;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (core_result),
    .zero_o   (core_zero),
    .neg_o    (core_neg),
    .err_o    (core_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_zero_d  = s2_zero_q;
    s2_neg_d   = s2_neg_q;
    s2_err_d   = s2_err_q;
    cnt_d      = cnt_q;

    if (s1_adv) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.req_op;
      s1_a_d     = bus.req_a;
      s1_b_d     = bus.req_b;
      s1_tag_d   = bus.req_tag;
    end

    if (consume) s2_valid_d = 1'b0;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = core_result;
      s2_tag_d   = s1_tag_q;
      s2_zero_d  = core_zero;
      s2_neg_d   = core_neg;
      s2_err_d   = core_err;
    end

    if (consume) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_zero_q  <= s2_zero_d;
      s2_neg_q   <= s2_neg_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready = !s1_valid_q || s2_free;
  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_data  = s2_data_q;
  assign bus.rsp_tag   = s2_tag_q;
  assign bus.rsp_zero  = s2_zero_q;
  assign bus.rsp_neg   = s2_neg_q;
  assign bus.rsp_err   = s2_err_q;
  assign done_count_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_op_responder
// Brief  : Directed and random bench for logic_op_responder (CNT_W = 4).
// Rev    : 1.0
// ============================================================================
module tb_logic_op_responder;
  import logic_op_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    logic        zero;
    logic        neg;
    logic        err;
    int          age;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] done_count;

  int   checks    = 0;
  int   errors    = 0;
  int   cnt_model = 0;
  bit   last_acc  = 1'b0;
  exp_t q[$];

  logic_op_responder_if #(.WIDTH(16), .TAG_W(4)) bus ();

  logic_op_responder #(.WIDTH(16), .TAG_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .done_count_o (done_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(input logic [2:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] tag);
    exp_t e;
    e.err = 1'b0;
    case (op)
      3'd0:    e.data = a & b;
      3'd1:    e.data = a | b;
      3'd2:    e.data = a ^ b;
      3'd3:    e.data = ~(a | b);
      3'd4:    e.data = ~(a & b);
      3'd5:    e.data = a & ~b;
      3'd6:    e.data = a;
      default: begin e.data = 16'h0000; e.err = 1'b1; end
    endcase
    e.zero = (e.data == 16'h0000);
    e.neg  = e.data[15];
    e.tag  = tag;
    e.age  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One clock: compare outputs against the occupancy model, then advance it.
  task automatic tick();
    logic ev, er, acc, cons;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [3:0]  tg;
    #1;
    ev = (q.size() > 0) && (q[0].age >= 1);
    er = (q.size() < 2) || bus.rsp_ready;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (ev) begin
      chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
      chk("rsp_tag",  32'(bus.rsp_tag),  32'(q[0].tag));
      chk("rsp_zero", 32'(bus.rsp_zero), 32'(q[0].zero));
      chk("rsp_neg",  32'(bus.rsp_neg),  32'(q[0].neg));
      chk("rsp_err",  32'(bus.rsp_err),  32'(q[0].err));
    end
    chk("done_count", 32'(done_count), 32'(cnt_model % 16));
    cons = ev && bus.rsp_ready;
    acc  = bus.req_valid && er;
    op = bus.req_op; a = bus.req_a; b = bus.req_b; tg = bus.req_tag;
    @(posedge clk);
    if (cons) begin
      void'(q.pop_front());
      cnt_model++;
    end
    foreach (q[i]) q[i].age++;
    if (acc) q.push_back(ref_model(op, a, b, tg));
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] tag);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op_e'(op);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept for tag %0d", tag);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  // Lone request: response visible one edge after acceptance, fixed values.
  task automatic single(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] d,
                        input logic z, input logic ng, input logic er);
    bus.rsp_ready = 1'b1;
    send(op, a, b, tag);
    tick();
    #1;
    chk("lat_valid", 32'(bus.rsp_valid), 32'd1);
    chk("lat_data",  32'(bus.rsp_data),  32'(d));
    chk("lat_tag",   32'(bus.rsp_tag),   32'(tag));
    chk("lat_zero",  32'(bus.rsp_zero),  32'(z));
    chk("lat_neg",   32'(bus.rsp_neg),   32'(ng));
    chk("lat_err",   32'(bus.rsp_err),   32'(er));
    drain();
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("rst_done_count", 32'(done_count),    32'd0);
    q.delete();
    cnt_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_AND;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Basic ops and flags with known answers
    single(3'd0, 16'h0003, 16'h0003, 4'd1, 16'h0003, 1'b0, 1'b0, 1'b0);
    single(3'd0, 16'h0015, 16'h0009, 4'd2, 16'h0001, 1'b0, 1'b0, 1'b0);
    single(3'd0, 16'h0008, 16'h0001, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0);
    single(3'd2, 16'h8000, 16'h0001, 4'd4, 16'h8001, 1'b0, 1'b1, 1'b0);
    single(3'd3, 16'h0000, 16'h0000, 4'd5, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    single(3'd5, 16'h00FF, 16'h000F, 4'd6, 16'h00F0, 1'b0, 1'b0, 1'b0);
    single(3'd6, 16'h1234, 16'hABCD, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b0);
    single(3'd7, 16'hFFFF, 16'hFFFF, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Streaming: 8 back-to-back from a fresh counter
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 16'(i * 16'h1111), 16'h0F0F, 4'(i));
    drain();
    chk("stream_count", 32'(done_count), 32'd8);

    // Backpressure: tag 3 must stall while tags 1 and 2 fill the pipe
    bus.rsp_ready = 1'b0;
    send(3'd1, 16'h0001, 16'h0000, 4'd1);
    send(3'd1, 16'h0002, 16'h0000, 4'd2);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_OR;
    bus.req_a     = 16'h0003;
    bus.req_b     = 16'h0000;
    bus.req_tag   = 4'd3;
    repeat (3) begin
      tick();
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_tag",   32'(bus.rsp_tag),   32'd1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_accept_tag3", 32'(last_acc), 32'd1);
    drain();

    // Randomized traffic with random backpressure
    last_acc      = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!(bus.req_valid && !last_acc)) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_op    = op_e'(3'($urandom_range(0, 7)));
        bus.req_a     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        bus.req_b     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        bus.req_tag   = 4'(i);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with both stages occupied, then a clean first request
    bus.rsp_ready = 1'b0;
    send(3'd6, 16'hDEAD, 16'h0000, 4'd9);
    send(3'd6, 16'hBEEF, 16'h0000, 4'd10);
    do_reset();
    bus.rsp_ready = 1'b1;
    tick();
    single(3'd6, 16'h5A5A, 16'h0000, 4'd11, 16'h5A5A, 1'b0, 1'b0, 1'b0);

    // Counter wrap on the 4-bit counter
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(3'd2, 16'(i), 16'h00FF, 4'(i));
    drain();
    tick();
    chk("wrap_count", 32'(done_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
